evz_responder: RTL and testbench

EVZ_RESPONDER -- requirements
Module: evz_responder

---
 rtl/evz_pkg.sv | 21 ++
 rtl/evz_sync.sv | 25 ++
 rtl/evz_responder.sv | 144 ++++++++++++++
 tb/tb_evz_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/evz_pkg.sv
// evz_pkg: shared types and constants for the dual-rail parity responder.
//   evz_state_e  - responder FSM states
//   SPACER/D0/D1/ILLEGAL - dual-rail codewords as {bit1, bit0}
//   TOKEN_CNT_W  - width of the optional accepted-token counter
package evz_pkg;

  typedef enum logic [1:0] {
    WAIT_NULL = 2'd0,
    NULL      = 2'd1,
    DATA      = 2'd2,
    ERR       = 2'd3
  } evz_state_e;

  localparam logic [1:0] SPACER  = 2'b00;
  localparam logic [1:0] D0      = 2'b01;
  localparam logic [1:0] D1      = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  localparam int unsigned TOKEN_CNT_W = 8;

endpackage

// File: rtl/evz_sync.sv
// evz_sync: STAGES-deep flop chain bringing one asynchronous rail into clk.
// Ports:
//   clk   - sampling clock
//   rst_n - synchronous active-low reset, clears every stage
//   d     - asynchronous input rail
//   q     - synchronized rail (last stage)
module evz_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= {chain_q[STAGES-2:0], d};
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/evz_responder.sv
// evz_responder: accepts dual-rail tokens under a four-phase return-to-zero
// handshake and answers, on a dual-rail result, whether the number of "0"
// tokens accepted since reset is even (parity0) or odd (parity1).
// Ports:
//   clk         - single clock, rising edge
//   rst_n       - synchronous active-low reset
//   bit0, bit1  - asynchronous dual-rail input ("0" rail, "1" rail)
//   parity0     - result rail: zero count even
//   parity1     - result rail: zero count odd
//   err         - sticky illegal-codeword flag, cleared only by reset
//   token_count - accepted-token counter, present only with EVZ_TOKEN_COUNT_EN
// Parameter SYNC_STAGES (2..4): synchronizer depth per rail.
module evz_responder
  import evz_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit0,
  input  logic bit1,
  output logic parity0,
  output logic parity1,
  output logic err
`ifdef EVZ_TOKEN_COUNT_EN
  ,
  output logic [TOKEN_CNT_W-1:0] token_count
`endif
);

  logic             bit0_s;
  logic             bit1_s;
  logic [1:0]       cw;
  logic [SYNC_STAGES-1:0] prime_q;
  logic             sync_ok;

  evz_state_e state_q;
  evz_state_e state_d;
  logic       odd_q;
  logic       odd_d;
  logic       parity0_d;
  logic       parity1_d;
  logic       err_d;

  // Rail synchronizers
  evz_sync #(.STAGES(SYNC_STAGES)) u_sync0 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bit0),
    .q     (bit0_s)
  );

  evz_sync #(.STAGES(SYNC_STAGES)) u_sync1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bit1),
    .q     (bit1_s)
  );

  assign cw = {bit1_s, bit0_s};

  // The reset zeros in the synchronizers look like a spacer; this marker
  // travels alongside them so WAIT_NULL only trusts real post-reset samples.
  always_ff @(posedge clk) begin
    if (!rst_n) prime_q <= '0;
    else        prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_ok = prime_q[SYNC_STAGES-1];

  // Next-state, parity and registered-output computation
  always_comb begin
    state_d = state_q;
    odd_d   = odd_q;

    case (state_q)
      WAIT_NULL: begin
        if (sync_ok) begin
          if (cw == ILLEGAL)     state_d = ERR;
          else if (cw == SPACER) state_d = NULL;
        end
      end
      NULL: begin
        case (cw)
          ILLEGAL: state_d = ERR;
          D0: begin
            odd_d   = ~odd_q;
            state_d = DATA;
          end
          D1:      state_d = DATA;
          default: state_d = NULL;
        endcase
      end
      DATA: begin
        // Data-to-data changes are not new tokens; only a spacer releases.
        if (cw == ILLEGAL)     state_d = ERR;
        else if (cw == SPACER) state_d = NULL;
      end
      ERR:     state_d = ERR;
      default: state_d = WAIT_NULL;
    endcase

    // Outputs follow the next state so they land with it on the same edge.
    parity0_d = (state_d == DATA) && !odd_d;
    parity1_d = (state_d == DATA) &&  odd_d;
    err_d     = (state_d == ERR);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_NULL;
      odd_q   <= 1'b0;
      parity0 <= 1'b0;
      parity1 <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      odd_q   <= odd_d;
      parity0 <= parity0_d;
      parity1 <= parity1_d;
      err     <= err_d;
    end
  end

`ifdef EVZ_TOKEN_COUNT_EN
  logic [TOKEN_CNT_W-1:0] cnt_q;
  logic [TOKEN_CNT_W-1:0] cnt_d;

  // Counts accepted tokens; ERR never enters DATA so the count freezes there.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == NULL) && (state_d == DATA)) cnt_d = cnt_q + TOKEN_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign token_count = cnt_q;
`endif

endmodule

// File: tb/tb_evz_responder.sv
// tb_evz_responder: self-checking bench for evz_responder. Define
// EVZ_TOKEN_COUNT_EN for both bench and RTL to cover the token counter.
module tb_evz_responder;

  localparam int unsigned SS     = 2;
  localparam int          LAT    = SS + 1;
  localparam int          BUDGET = 4 * (SS + 1) + 8;
`ifdef EVZ_TOKEN_COUNT_EN
  localparam int          NWRAP  = 256;
`else
  localparam int          NWRAP  = 16;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic bit0;
  logic bit1;
  logic parity0;
  logic parity1;
  logic err;
`ifdef EVZ_TOKEN_COUNT_EN
  logic [7:0] token_count;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  typedef struct {
    logic p0;
    logic p1;
  } rails_t;

  typedef struct {
    logic tok;
    logic p0;
    logic p1;
  } vec_t;

  rails_t sb_q[$];
  vec_t   vecs[8];

  evz_responder #(.SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit0    (bit0),
    .bit1    (bit1),
    .parity0 (parity0),
    .parity1 (parity1),
    .err     (err)
`ifdef EVZ_TOKEN_COUNT_EN
    ,
    .token_count (token_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result rails must never both be high.
  always @(negedge clk) begin
    if (mon_en) check("rails_exclusive", 32'(parity0 & parity1), 32'd0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bit0  = 1'b0;
    bit1  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) until the result rails are nonzero / zero; lat = edges seen.
  task automatic wait_rails(input logic want_nonzero, output int lat);
    lat = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk);
      #1;
      if ((parity0 | parity1) == want_nonzero) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic send_token(input logic tok, input logic ep0, input logic ep1, input string tag);
    rails_t e;
    int     lat;
    sb_q.push_back('{ep0, ep1});
    @(negedge clk);
    bit0 = ~tok;
    bit1 = tok;
    wait_rails(1'b1, lat);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_parity0"}, 32'(parity0), 32'(e.p0));
      check({tag, "_parity1"}, 32'(parity1), 32'(e.p1));
    end
  endtask

  task automatic send_spacer(input string tag);
    int lat;
    @(negedge clk);
    bit0 = 1'b0;
    bit1 = 1'b0;
    wait_rails(1'b0, lat);
    check({tag, "_spacer_latency"}, 32'(lat), 32'(LAT));
  endtask

  initial begin
    rst_n = 1'b0;
    bit0  = 1'b0;
    bit1  = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0};

    do_reset();
    mon_en = 1'b1;
    check("reset_parity0", 32'(parity0), 32'd0);
    check("reset_parity1", 32'(parity1), 32'd0);
    check("reset_err", 32'(err), 32'd0);
`ifdef EVZ_TOKEN_COUNT_EN
    check("reset_count", 32'(token_count), 32'd0);
`endif

    // Table-driven token sequence
    for (int i = 0; i < 8; i++) begin
      send_token(vecs[i].tok, vecs[i].p0, vecs[i].p1, $sformatf("vec%0d", i));
      send_spacer($sformatf("vec%0d", i));
`ifdef EVZ_TOKEN_COUNT_EN
      if (i == 3) check("count_after_4", 32'(token_count), 32'd4);
`endif
    end

    // Data-to-data switch without a spacer is not a new token
    send_token(1'b0, 1'b0, 1'b1, "switch_first");
    @(negedge clk);
    bit0 = 1'b0;
    bit1 = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("switch_parity0", 32'(parity0), 32'd0);
    check("switch_parity1", 32'(parity1), 32'd1);
    check("switch_err", 32'(err), 32'd0);
`ifdef EVZ_TOKEN_COUNT_EN
    check("switch_count", 32'(token_count), 32'd9);
`endif
    send_spacer("switch");
    send_token(1'b1, 1'b0, 1'b1, "after_switch");
    send_spacer("after_switch");

    // Reset mid-handshake with bit0 still high
    do_reset();
    send_token(1'b0, 1'b0, 1'b1, "pre_reset");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_parity0", 32'(parity0), 32'd0);
    check("midreset_parity1", 32'(parity1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * LAT) @(posedge clk);
    #1;
    check("held_parity0", 32'(parity0), 32'd0);
    check("held_parity1", 32'(parity1), 32'd0);
    check("held_err", 32'(err), 32'd0);
`ifdef EVZ_TOKEN_COUNT_EN
    check("held_count", 32'(token_count), 32'd0);
`endif
    @(negedge clk);
    bit0 = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    send_token(1'b1, 1'b1, 1'b0, "post_reset");
`ifdef EVZ_TOKEN_COUNT_EN
    check("post_reset_count", 32'(token_count), 32'd1);
`endif
    send_spacer("post_reset");

    // Illegal codeword: sticky error until reset
    @(negedge clk);
    bit0 = 1'b1;
    bit1 = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_parity0", 32'(parity0), 32'd0);
    check("illegal_parity1", 32'(parity1), 32'd0);
    @(negedge clk);
    bit0 = 1'b0;
    bit1 = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("err_after_spacer", 32'(err), 32'd1);
    @(negedge clk);
    bit0 = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("err_after_token", 32'(err), 32'd1);
    check("err_token_parity0", 32'(parity0), 32'd0);
    check("err_token_parity1", 32'(parity1), 32'd0);
`ifdef EVZ_TOKEN_COUNT_EN
    check("err_count_frozen", 32'(token_count), 32'd1);
`endif
    do_reset();
    check("err_cleared", 32'(err), 32'd0);

    // Repeated "1" tokens keep even parity (and wrap the counter when present)
    for (int i = 0; i < NWRAP; i++) begin
      send_token(1'b1, 1'b1, 1'b0, "wrap");
      send_spacer("wrap");
    end
`ifdef EVZ_TOKEN_COUNT_EN
    check("count_wrap", 32'(token_count), 32'd0);
`endif
    check("final_err", 32'(err), 32'd0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
